// File: rtl/fe_control_array.sv
// ---------------------------------------------------------------------------
// fe_control_array
//   Front-end control for NPIX pixels of one pixel region, all in the Clk
//   domain. Holds per-pixel configuration, drives the analogue front-end
//   controls, synchronises the active-low discriminator outputs and measures
//   time-over-threshold (ToT) per pixel with dead time and a stretched
//   digital-injection mode.
//
//   Configuration word per pixel (CFG_W = TDAC_W+4):
//     {sign, tdac[TDAC_W-1:0], hit_or_en, cal_en, hit_en}
//
//   Ports:
//     Clk, Reset_B          clock, asynchronous active-low reset
//     DefConf, DefCalEn     force the default configuration on every pixel
//     Wr, WrAddr, DataIn    configuration write port
//     RdAddr, DataOut       registered readback of the effective configuration
//     S0, S1                injection switch controls -> AfeS0/AfeS1 (gated)
//     CalEdge, EnDigHit     digital injection strobe and hit source select
//     DiscOut_B             discriminator outputs, active-low, asynchronous
//     Dth1, Dth2            threshold trim, pixel p at [p*TDAC_W +: TDAC_W]
//     HitOut, HitOr         per-pixel hit level and registered region OR
//     TotValid, Tot         one-cycle ToT strobe and ToT value per pixel
//     PowerDown             ~hit_en per pixel
// ---------------------------------------------------------------------------
module fe_control_array #(
    parameter int NPIX     = 4,
    parameter int TDAC_W   = 4,
    parameter int TOT_W    = 4,
    parameter int DEAD_CYC = 2,
    parameter int CAL_LEN  = 3,
    parameter int AW       = 2
) (
    input  logic                   Clk,
    input  logic                   Reset_B,
    input  logic                   DefConf,
    input  logic                   DefCalEn,
    input  logic                   Wr,
    input  logic [AW-1:0]          WrAddr,
    input  logic [TDAC_W+3:0]      DataIn,
    input  logic [AW-1:0]          RdAddr,
    output logic [TDAC_W+3:0]      DataOut,
    input  logic                   S0,
    input  logic                   S1,
    input  logic                   CalEdge,
    input  logic                   EnDigHit,
    input  logic [NPIX-1:0]        DiscOut_B,
    output logic [NPIX-1:0]        AfeS0,
    output logic [NPIX-1:0]        AfeS1,
    output logic [NPIX*TDAC_W-1:0] Dth1,
    output logic [NPIX*TDAC_W-1:0] Dth2,
    output logic [NPIX-1:0]        HitOut,
    output logic                   HitOr,
    output logic [NPIX-1:0]        TotValid,
    output logic [NPIX*TOT_W-1:0]  Tot,
    output logic [NPIX-1:0]        PowerDown
);

    localparam int CFG_W     = TDAC_W + 4;
    localparam int CAL_W     = $clog2(CAL_LEN + 1);
    localparam int DEAD_W    = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam int DEAD_LOAD = (DEAD_CYC > 0) ? DEAD_CYC - 1 : 0;

    localparam logic [CFG_W-1:0] CFG_RST = {1'b0, {TDAC_W{1'b1}}, 3'b000};
    localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DEAD,
        S_ARM
    } state_t;

    function automatic logic [TOT_W-1:0] tot_sat_inc(input logic [TOT_W-1:0] v);
        if (v == TOT_MAX) return v;
        return v + TOT_W'(1);
    endfunction

    logic [CFG_W-1:0] cfg_q   [NPIX];
    logic [CFG_W-1:0] eff_cfg [NPIX];
    logic [CFG_W-1:0] def_cfg;
    logic [CFG_W-1:0] rd_cfg;
    logic             cal_p0;
    logic             cal_p1;
    logic             cal_rise;
    logic [NPIX-1:0]  hit_q;
    logic [NPIX-1:0]  hit_or_vec;

    assign def_cfg  = {1'b0, {TDAC_W{1'b1}}, 1'b1, DefCalEn, 1'b1};
    assign cal_rise = cal_p0 & ~cal_p1;
    assign HitOut   = hit_q;

    // Stored configuration; DefConf only overrides the effective view.
    always_ff @(posedge Clk or negedge Reset_B) begin
        if (!Reset_B) begin
            for (int p = 0; p < NPIX; p++) cfg_q[p] <= CFG_RST;
        end else if (Wr) begin
            for (int p = 0; p < NPIX; p++) begin
                if (int'(WrAddr) == p) cfg_q[p] <= DataIn;
            end
        end
    end

    // Readback mux; addresses with no pixel fall through to zero.
    always_comb begin
        rd_cfg = '0;
        for (int p = 0; p < NPIX; p++) begin
            if (int'(RdAddr) == p) rd_cfg = eff_cfg[p];
        end
    end

    // Stage p0/p1: registered CalEdge and its delayed copy for edge detection
    always_ff @(posedge Clk or negedge Reset_B) begin
        if (!Reset_B) begin
            DataOut <= '0;
            cal_p0  <= 1'b0;
            cal_p1  <= 1'b0;
            HitOr   <= 1'b0;
        end else begin
            DataOut <= rd_cfg;
            cal_p0  <= CalEdge;
            cal_p1  <= cal_p0;
            HitOr   <= |hit_or_vec;
        end
    end

    for (genvar p = 0; p < NPIX; p++) begin : g_pix
        logic              sign;
        logic [TDAC_W-1:0] tdac;
        logic              hor_en;
        logic              cal_en;
        logic              hit_en;
        logic              disc_p0;
        logic              disc_p1;
        logic [CAL_W-1:0]  cal_cnt;
        logic              hit_a;
        logic              hit_d;
        logic              g;
        state_t            state;
        logic [TOT_W-1:0]  tot_cnt;
        logic [TOT_W-1:0]  tot_q;
        logic              vld_q;
        logic              hit_r;
        logic [DEAD_W-1:0] dead_cnt;

        assign eff_cfg[p] = DefConf ? def_cfg : cfg_q[p];
        assign sign       = eff_cfg[p][CFG_W-1];
        assign tdac       = eff_cfg[p][CFG_W-2 -: TDAC_W];
        assign hor_en     = eff_cfg[p][2];
        assign cal_en     = eff_cfg[p][1];
        assign hit_en     = eff_cfg[p][0];

        assign AfeS0[p]                   = cal_en ? S0 : 1'b1;
        assign AfeS1[p]                   = cal_en ? S1 : 1'b1;
        assign Dth1[p*TDAC_W +: TDAC_W]   = sign ? '0 : tdac;
        assign Dth2[p*TDAC_W +: TDAC_W]   = sign ? tdac : '0;
        assign PowerDown[p]               = ~hit_en;
        assign Tot[p*TOT_W +: TOT_W]      = tot_q;
        assign TotValid[p]                = vld_q;
        assign hit_q[p]                   = hit_r;
        assign hit_or_vec[p]              = hit_r & hor_en;

        assign hit_a = ~disc_p1;
        assign hit_d = (cal_cnt != '0);
        assign g     = (EnDigHit ? hit_d : hit_a) & hit_en;

        // Stage p0/p1: two-flop synchroniser, idles high (no hit)
        always_ff @(posedge Clk or negedge Reset_B) begin
            if (!Reset_B) begin
                disc_p0 <= 1'b1;
                disc_p1 <= 1'b1;
            end else begin
                disc_p0 <= DiscOut_B[p];
                disc_p1 <= disc_p0;
            end
        end

        // Injection stretcher: a re-trigger while running simply reloads.
        always_ff @(posedge Clk or negedge Reset_B) begin
            if (!Reset_B) begin
                cal_cnt <= '0;
            end else if (cal_rise && cal_en) begin
                cal_cnt <= CAL_W'(CAL_LEN);
            end else if (cal_cnt != '0) begin
                cal_cnt <= cal_cnt - CAL_W'(1);
            end
        end

        // ToT state machine; hit_r mirrors "state is COUNT" as a register.
        always_ff @(posedge Clk or negedge Reset_B) begin
            if (!Reset_B) begin
                state    <= S_IDLE;
                tot_cnt  <= '0;
                tot_q    <= '0;
                vld_q    <= 1'b0;
                hit_r    <= 1'b0;
                dead_cnt <= '0;
            end else begin
                vld_q <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (g) begin
                            state   <= S_COUNT;
                            tot_cnt <= TOT_W'(1);
                            hit_r   <= 1'b1;
                        end
                    end
                    S_COUNT: begin
                        if (!hit_en) begin
                            // Masked mid-hit: drop the measurement silently.
                            state <= S_IDLE;
                            hit_r <= 1'b0;
                        end else if (g) begin
                            tot_cnt <= tot_sat_inc(tot_cnt);
                        end else begin
                            tot_q <= tot_cnt;
                            vld_q <= 1'b1;
                            hit_r <= 1'b0;
                            if (DEAD_CYC == 0) begin
                                state <= S_ARM;
                            end else begin
                                state    <= S_DEAD;
                                dead_cnt <= DEAD_W'(DEAD_LOAD);
                            end
                        end
                    end
                    S_DEAD: begin
                        if (dead_cnt == '0) state <= S_ARM;
                        else dead_cnt <= dead_cnt - DEAD_W'(1);
                    end
                    S_ARM: begin
                        // Require a release so a long hit is never counted twice.
                        if (!g) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fe_control_array.sv
module tb_fe_control_array;

    localparam int NPIX     = 4;
    localparam int TDAC_W   = 4;
    localparam int TOT_W    = 4;
    localparam int DEAD_CYC = 2;
    localparam int CAL_LEN  = 3;
    localparam int AW       = 3;
    localparam int CFG_W    = TDAC_W + 4;
    localparam int TOT_MAX  = (1 << TOT_W) - 1;

    logic                   Clk = 1'b0;
    logic                   Reset_B;
    logic                   DefConf;
    logic                   DefCalEn;
    logic                   Wr;
    logic [AW-1:0]          WrAddr;
    logic [CFG_W-1:0]       DataIn;
    logic [AW-1:0]          RdAddr;
    logic [CFG_W-1:0]       DataOut;
    logic                   S0;
    logic                   S1;
    logic                   CalEdge;
    logic                   EnDigHit;
    logic [NPIX-1:0]        DiscOut_B;
    logic [NPIX-1:0]        AfeS0;
    logic [NPIX-1:0]        AfeS1;
    logic [NPIX*TDAC_W-1:0] Dth1;
    logic [NPIX*TDAC_W-1:0] Dth2;
    logic [NPIX-1:0]        HitOut;
    logic                   HitOr;
    logic [NPIX-1:0]        TotValid;
    logic [NPIX*TOT_W-1:0]  Tot;
    logic [NPIX-1:0]        PowerDown;

    fe_control_array #(
        .NPIX(NPIX), .TDAC_W(TDAC_W), .TOT_W(TOT_W),
        .DEAD_CYC(DEAD_CYC), .CAL_LEN(CAL_LEN), .AW(AW)
    ) dut (
        .Clk(Clk), .Reset_B(Reset_B), .DefConf(DefConf), .DefCalEn(DefCalEn),
        .Wr(Wr), .WrAddr(WrAddr), .DataIn(DataIn), .RdAddr(RdAddr),
        .DataOut(DataOut), .S0(S0), .S1(S1), .CalEdge(CalEdge),
        .EnDigHit(EnDigHit), .DiscOut_B(DiscOut_B), .AfeS0(AfeS0),
        .AfeS1(AfeS1), .Dth1(Dth1), .Dth2(Dth2), .HitOut(HitOut),
        .HitOr(HitOr), .TotValid(TotValid), .Tot(Tot), .PowerDown(PowerDown)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [CFG_W-1:0] m_cfg [NPIX];
    bit               m_s1 [NPIX];
    bit               m_s2 [NPIX];
    int               m_rem [NPIX];
    bit               m_calq, m_calq_prev;
    bit               m_counting [NPIX];
    int               m_tot [NPIX];
    int               m_dead [NPIX];
    bit               m_wait [NPIX];
    int               m_tot_out [NPIX];
    bit               m_valid [NPIX];
    bit               m_hitor;
    logic [CFG_W-1:0] m_dout;

    function automatic logic [CFG_W-1:0] m_eff(input int p);
        if (DefConf) return {1'b0, {TDAC_W{1'b1}}, 1'b1, DefCalEn, 1'b1};
        return m_cfg[p];
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NPIX; p++) begin
            m_cfg[p]      = {1'b0, {TDAC_W{1'b1}}, 3'b000};
            m_s1[p]       = 1'b1;
            m_s2[p]       = 1'b1;
            m_rem[p]      = 0;
            m_counting[p] = 1'b0;
            m_tot[p]      = 0;
            m_dead[p]     = 0;
            m_wait[p]     = 1'b0;
            m_tot_out[p]  = 0;
            m_valid[p]    = 1'b0;
        end
        m_calq      = 1'b0;
        m_calq_prev = 1'b0;
        m_hitor     = 1'b0;
        m_dout      = '0;
    endtask

    // One clock edge: every rule reads the values present just before it.
    task automatic model_step();
        logic [CFG_W-1:0] e [NPIX];
        bit rise, hor, g, hen;
        for (int p = 0; p < NPIX; p++) e[p] = m_eff(p);
        rise = m_calq && !m_calq_prev;
        hor  = 1'b0;
        for (int p = 0; p < NPIX; p++) hor |= m_counting[p] && e[p][2];
        m_dout = (int'(RdAddr) < NPIX) ? e[int'(RdAddr)] : '0;
        for (int p = 0; p < NPIX; p++) begin
            hen = e[p][0];
            g   = (EnDigHit ? (m_rem[p] > 0) : !m_s2[p]) && hen;
            m_valid[p] = 1'b0;
            if (m_counting[p]) begin
                if (!hen) m_counting[p] = 1'b0;
                else if (g) m_tot[p] = (m_tot[p] + 1 > TOT_MAX) ? TOT_MAX : m_tot[p] + 1;
                else begin
                    m_tot_out[p]  = m_tot[p];
                    m_valid[p]    = 1'b1;
                    m_counting[p] = 1'b0;
                    m_dead[p]     = DEAD_CYC;
                    m_wait[p]     = 1'b1;
                end
            end else if (m_dead[p] > 0) begin
                m_dead[p]--;
            end else if (m_wait[p]) begin
                if (!g) m_wait[p] = 1'b0;
            end else if (g) begin
                m_counting[p] = 1'b1;
                m_tot[p]      = 1;
            end
            if (rise && e[p][1]) m_rem[p] = CAL_LEN;
            else if (m_rem[p] > 0) m_rem[p]--;
            m_s2[p] = m_s1[p];
            m_s1[p] = DiscOut_B[p];
        end
        m_hitor     = hor;
        m_calq_prev = m_calq;
        m_calq      = CalEdge;
        if (Wr && int'(WrAddr) < NPIX) m_cfg[int'(WrAddr)] = DataIn;
    endtask

    task automatic check_all();
        logic [CFG_W-1:0] e;
        logic [TDAC_W-1:0] td;
        for (int p = 0; p < NPIX; p++) begin
            e  = m_eff(p);
            td = e[CFG_W-2 -: TDAC_W];
            chk($sformatf("HitOut[%0d]", p), 64'(HitOut[p]), 64'(m_counting[p]));
            chk($sformatf("TotValid[%0d]", p), 64'(TotValid[p]), 64'(m_valid[p]));
            chk($sformatf("Tot[%0d]", p), 64'(Tot[p*TOT_W +: TOT_W]), 64'(m_tot_out[p]));
            chk($sformatf("AfeS0[%0d]", p), 64'(AfeS0[p]), 64'(e[1] ? S0 : 1'b1));
            chk($sformatf("AfeS1[%0d]", p), 64'(AfeS1[p]), 64'(e[1] ? S1 : 1'b1));
            chk($sformatf("Dth1[%0d]", p), 64'(Dth1[p*TDAC_W +: TDAC_W]), 64'(e[CFG_W-1] ? '0 : td));
            chk($sformatf("Dth2[%0d]", p), 64'(Dth2[p*TDAC_W +: TDAC_W]), 64'(e[CFG_W-1] ? td : '0));
            chk($sformatf("PowerDown[%0d]", p), 64'(PowerDown[p]), 64'(!e[0]));
        end
        chk("HitOr", 64'(HitOr), 64'(m_hitor));
        chk("DataOut", 64'(DataOut), 64'(m_dout));
    endtask

    task automatic tick();
        @(posedge Clk);
        if (Reset_B) model_step();
        else model_reset();
        @(negedge Clk);
        check_all();
    endtask

    task automatic write_cfg(input int addr, input logic [CFG_W-1:0] d);
        Wr = 1'b1; WrAddr = AW'(addr); DataIn = d;
        tick();
        Wr = 1'b0;
    endtask

    // ---------------- configuration vector table ----------------
    typedef struct {
        bit               wr;
        logic [AW-1:0]    wa;
        logic [CFG_W-1:0] din;
        bit               dc;
        bit               dce;
        logic [AW-1:0]    ra;
        bit               s0;
        int               pix;
        logic [CFG_W-1:0] e_do;
        logic [3:0]       e_dth1;
        logic [3:0]       e_dth2;
        bit               e_afes0;
        bit               e_pd;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int first_hit, first_or, hit_cyc, nvalid, tot_seen, k;
        int tots [4];
        int vfirst [NPIX];
        int vtot [NPIX];
        int lvl [6];
        int len [6];

        tbl[0] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b0, 2, 8'h7D, 4'hF, 4'h0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0, 2, 8'h78, 4'hF, 4'h0, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 3'd1, 8'h9D, 1'b0, 1'b0, 3'd1, 1'b0, 1, 8'h9D, 4'h0, 4'h3, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 3'd1, 1'b0, 1, 8'h9D, 4'h0, 4'h3, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 3'd0, 8'h43, 1'b0, 1'b0, 3'd0, 1'b0, 0, 8'h43, 4'h8, 4'h0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 0, 8'h43, 4'h8, 4'h0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd5, 1'b1, 1, 8'h00, 4'h0, 4'h3, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 0, 8'h7F, 4'hF, 4'h0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 0, 8'h43, 4'h8, 4'h0, 1'b0, 1'b0};

        Reset_B = 1'b0; DefConf = 1'b0; DefCalEn = 1'b0; Wr = 1'b0;
        WrAddr = '0; DataIn = '0; RdAddr = '0; S0 = 1'b0; S1 = 1'b0;
        CalEdge = 1'b0; EnDigHit = 1'b0; DiscOut_B = '1;
        model_reset();
        tick();
        tick();
        chk("rst_DataOut", 64'(DataOut), 64'h0);
        chk("rst_HitOut", 64'(HitOut), 64'h0);
        chk("rst_TotValid", 64'(TotValid), 64'h0);
        chk("rst_Tot", 64'(Tot), 64'h0);
        chk("rst_HitOr", 64'(HitOr), 64'h0);
        chk("rst_PowerDown", 64'(PowerDown), 64'hF);
        Reset_B = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            Wr = tbl[i].wr; WrAddr = tbl[i].wa; DataIn = tbl[i].din;
            DefConf = tbl[i].dc; DefCalEn = tbl[i].dce; RdAddr = tbl[i].ra; S0 = tbl[i].s0;
            tick();
            Wr = 1'b0;
            tick();
            chk($sformatf("tbl%0d_DataOut", i), 64'(DataOut), 64'(tbl[i].e_do));
            chk($sformatf("tbl%0d_Dth1", i), 64'(Dth1[tbl[i].pix*TDAC_W +: TDAC_W]), 64'(tbl[i].e_dth1));
            chk($sformatf("tbl%0d_Dth2", i), 64'(Dth2[tbl[i].pix*TDAC_W +: TDAC_W]), 64'(tbl[i].e_dth2));
            chk($sformatf("tbl%0d_AfeS0", i), 64'(AfeS0[tbl[i].pix]), 64'(tbl[i].e_afes0));
            chk($sformatf("tbl%0d_PowerDown", i), 64'(PowerDown[tbl[i].pix]), 64'(tbl[i].e_pd));
        end

        DefConf = 1'b0; DefCalEn = 1'b0; S0 = 1'b0;
        write_cfg(0, 8'h07);
        write_cfg(1, 8'h05);
        write_cfg(2, 8'h07);
        write_cfg(3, 8'h05);
        repeat (3) tick();

        // Analogue hit of 6 cycles on pixel 0
        first_hit = -1; first_or = -1; hit_cyc = 0; nvalid = 0; tot_seen = -1;
        DiscOut_B[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 5) DiscOut_B[0] = 1'b1;
            if (HitOut[0]) begin
                if (first_hit < 0) first_hit = i;
                hit_cyc++;
            end
            if (HitOr && first_or < 0) first_or = i;
            if (TotValid[0]) begin
                nvalid++;
                tot_seen = int'(Tot[TOT_W-1:0]);
            end
        end
        chk("a_latency", 64'(first_hit), 64'd2);
        chk("a_hit_cycles", 64'(hit_cyc), 64'd6);
        chk("a_hitor_latency", 64'(first_or), 64'd3);
        chk("a_nvalid", 64'(nvalid), 64'd1);
        chk("a_tot", 64'(tot_seen), 64'd6);

        // Saturation and re-arm on pixel 3
        lvl = '{0, 1, 0, 1, 0, 1};
        len = '{20, 1, 15, 5, 4, 30};
        nvalid = 0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < len[r]; c++) begin
                DiscOut_B[3] = lvl[r][0];
                tick();
                if (TotValid[3]) begin
                    if (nvalid < 4) tots[nvalid] = int'(Tot[3*TOT_W +: TOT_W]);
                    nvalid++;
                end
            end
        end
        chk("b_nvalid", 64'(nvalid), 64'd2);
        chk("b_tot_sat", 64'(tots[0]), 64'd15);
        chk("b_tot_rearm", 64'(tots[1]), 64'd4);

        // Digital injection on pixels 0 and 2
        EnDigHit = 1'b1;
        tick();
        CalEdge = 1'b1;
        tick();
        CalEdge = 1'b0;
        for (int p = 0; p < NPIX; p++) begin vfirst[p] = -1; vtot[p] = -1; end
        for (int i = 0; i < 12; i++) begin
            tick();
            for (int p = 0; p < NPIX; p++) begin
                if (TotValid[p] && vfirst[p] < 0) begin
                    vfirst[p] = i;
                    vtot[p]   = int'(Tot[p*TOT_W +: TOT_W]);
                end
            end
        end
        chk("c_pix0_when", 64'(vfirst[0]), 64'd4);
        chk("c_pix2_when", 64'(vfirst[2]), 64'd4);
        chk("c_pix0_tot", 64'(vtot[0]), 64'd3);
        chk("c_pix2_tot", 64'(vtot[2]), 64'd3);
        chk("c_pix1_silent", 64'(vfirst[1]), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("c_pix3_silent", 64'(vfirst[3]), 64'hFFFF_FFFF_FFFF_FFFF);
        EnDigHit = 1'b0;
        repeat (3) tick();

        // Mask pixel 1 in the middle of a hit
        DiscOut_B[1] = 1'b0;
        k = 0;
        while (!HitOut[1] && k < 10) begin tick(); k++; end
        chk("d_hit_start", 64'(HitOut[1]), 64'd1);
        repeat (2) tick();
        write_cfg(1, 8'h04);
        chk("d_hit_hold", 64'(HitOut[1]), 64'd1);
        tick();
        chk("d_hit_drop", 64'(HitOut[1]), 64'd0);
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (TotValid[1]) nvalid++;
        end
        chk("d_no_valid", 64'(nvalid), 64'd0);
        chk("d_tot_kept", 64'(Tot[1*TOT_W +: TOT_W]), 64'd0);
        DiscOut_B[1] = 1'b1;
        repeat (3) tick();

        // Asynchronous reset in the middle of a hit on pixel 2
        DiscOut_B[2] = 1'b0;
        k = 0;
        while (!HitOut[2] && k < 10) begin tick(); k++; end
        chk("e_hit_start", 64'(HitOut[2]), 64'd1);
        tick();
        #2 Reset_B = 1'b0;
        #1;
        model_reset();
        chk("e_HitOut", 64'(HitOut), 64'h0);
        chk("e_TotValid", 64'(TotValid), 64'h0);
        chk("e_Tot", 64'(Tot), 64'h0);
        chk("e_HitOr", 64'(HitOr), 64'h0);
        chk("e_DataOut", 64'(DataOut), 64'h0);
        DiscOut_B = '1;
        tick();
        Reset_B = 1'b1;
        tick();

        // Randomised traffic against the model
        write_cfg(0, 8'h07);
        write_cfg(1, 8'h07);
        write_cfg(2, 8'h05);
        write_cfg(3, 8'h07);
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < NPIX; p++) begin
                if ($urandom_range(0, 4) == 0) DiscOut_B[p] = ~DiscOut_B[p];
            end
            Wr     = ($urandom_range(0, 15) == 0);
            WrAddr = AW'($urandom_range(0, 7));
            DataIn = CFG_W'($urandom);
            DataIn[0] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) DefConf = ~DefConf;
            DefCalEn = 1'($urandom_range(0, 1));
            CalEdge  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) EnDigHit = ~EnDigHit;
            S0     = 1'($urandom_range(0, 1));
            S1     = 1'($urandom_range(0, 1));
            RdAddr = AW'($urandom_range(0, 7));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
